// File: rtl/pwrgd_pkg.sv
// Shared definitions for the power-good aggregator: FSM state encoding and
// the default rail debounce length.
package pwrgd_pkg;

  localparam int STATE_W        = 2;
  localparam int DEB_CYCLES_DEF = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'b00,
    ST_DELAY = 2'b01,
    ST_PWROK = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

endpackage

// File: rtl/pwrgd_glitch_filter.sv
// Single-rail glitch filter. The output follows the input only after the
// input has disagreed with the output for DEB_CYCLES consecutive cycles.
// Any agreeing cycle restarts the count.
module pwrgd_glitch_filter #(
  parameter int DEB_CYCLES = 3
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iIn,
  output logic oOut
);

  localparam logic [3:0] CNT_LAST = 4'(DEB_CYCLES - 1);

  logic [3:0] cnt;

  // Mismatch counter and filtered level
  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt  <= '0;
      oOut <= 1'b0;
    end else if (iIn == oOut) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      oOut <= iIn;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwrgd_aggregate_seq.sv
// Power-good aggregator. Filters each rail power-good, combines the required
// rails with SLP_S3# and PS_PWROK, asserts PWROK after a programmable ms
// delay, drops it at once on loss and records a first-fail snapshot.
// Optional build macro: PWRGD_PS_RECOVERY_EN lets a PSU-only fault return to
// DELAY on its own once everything is good again (fault flags stay sticky).
module pwrgd_aggregate_seq
  import pwrgd_pkg::*;
#(
  parameter int NUM_RAILS  = 8,
  parameter int DLY_BITS   = 8,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 i1mSCE,
  input  logic [NUM_RAILS-1:0] ivRailPwrgd,
  input  logic [NUM_RAILS-1:0] ivRailMask,
  input  logic                 iSlpS3_n,
  input  logic                 iPsPwrok,
  input  logic [DLY_BITS-1:0]  ivAssertDlyMs,
  input  logic                 iSysEnable,
  input  logic                 iFaultClr,
  output logic                 oPwrok,
  output logic                 oSysPwrok,
  output logic                 oFault,
  output logic [NUM_RAILS:0]   ovFaultRail,
  output logic [STATE_W-1:0]   ovState
);

  localparam logic [NUM_RAILS:0] PSU_ONLY = {1'b1, {NUM_RAILS{1'b0}}};

  logic [NUM_RAILS-1:0] vRailFilt;
  logic                 railsOk;
  logic                 allGood;
  logic                 enterDelay;
  logic                 psRecover;
  state_t               state;
  logic [DLY_BITS-1:0]  msCnt;
  logic [DLY_BITS-1:0]  dlyLatched;

  for (genvar gi = 0; gi < NUM_RAILS; gi++) begin : gFilt
    pwrgd_glitch_filter #(
      .DEB_CYCLES(DEB_CYCLES)
    ) uFilt (
      .iClk(iClk),
      .iRst(iRst),
      .iIn (ivRailPwrgd[gi]),
      .oOut(vRailFilt[gi])
    );
  end

  assign railsOk = &(vRailFilt | ~ivRailMask);
  assign allGood = railsOk & iSlpS3_n & iPsPwrok;

`ifdef PWRGD_PS_RECOVERY_EN
  assign psRecover = (state == ST_FAULT) & ~iFaultClr & (ovFaultRail == PSU_ONLY) & allGood;
`else
  assign psRecover = 1'b0;
`endif

  assign enterDelay = ((state == ST_IDLE) & allGood) | psRecover;

  // Sequencer FSM, ms counter, sticky fault capture and SYS_PWROK register
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state       <= ST_IDLE;
      msCnt       <= '0;
      oFault      <= 1'b0;
      ovFaultRail <= '0;
      oSysPwrok   <= 1'b0;
    end else begin
      oSysPwrok <= oPwrok & iSysEnable;
      // Clear first so that a simultaneous FAULT entry below takes priority
      if (iFaultClr) begin
        oFault      <= 1'b0;
        ovFaultRail <= '0;
      end
      if (enterDelay) begin
        state <= ST_DELAY;
        msCnt <= '0;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_DELAY: begin
            if (!allGood) begin
              state <= ST_IDLE;
            end else if (msCnt == dlyLatched) begin
              state <= ST_PWROK;
            end else if (i1mSCE && (msCnt != '1)) begin
              msCnt <= msCnt + 1'b1;
            end
          end
          ST_PWROK: begin
            // Orderly shutdown beats any rail/PSU drop seen on the same edge
            if (!iSlpS3_n) begin
              state <= ST_IDLE;
            end else if (!railsOk || !iPsPwrok) begin
              state       <= ST_FAULT;
              oFault      <= 1'b1;
              ovFaultRail <= {~iPsPwrok, ivRailMask & ~vRailFilt};
            end
          end
          ST_FAULT: begin
            if (iFaultClr) begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Delay target captured on every entry into DELAY
  always_ff @(posedge iClk) begin
    if (enterDelay) begin
      dlyLatched <= ivAssertDlyMs;
    end
  end

  assign oPwrok  = (state == ST_PWROK);
  assign ovState = state;

endmodule

// File: doc/pwrgd_aggregate_seq.md
Name: pwrgd_aggregate_seq

Overview:
- Parametrised power-good aggregator; next generation of the platform PWROK generator.
- Combines NUM_RAILS rail power-goods (runtime maskable) with SLP_S3# and the delayed PS_PWROK, each rail glitch-filtered.
- Asserts PWROK after a runtime-programmable ms delay. Deasserts immediately on loss.
- Captures a first-fail rail snapshot. Drives SYS_PWROK gated by the debug-port enable. Sits between per-rail sequencers and the PCH/CPU power-good pins.

Parameters:
- NUM_RAILS, 8, number of rail power-good inputs (1..32)
- DLY_BITS, 8, width of the ms delay counter and delay input
- DEB_CYCLES, 3, consecutive stable iClk cycles before a filtered rail changes (1..15)

Ports:
- iClk  in  1  system clock; single clock domain
- iRst  in  1  reset; synchronous, active-high
- i1mSCE  in  1  one-cycle 1 ms clock enable
- ivRailPwrgd  in  NUM_RAILS  raw rail power-goods, already synchronous
- ivRailMask  in  NUM_RAILS  1 = rail required; 0 = ignored
- iSlpS3_n  in  1  SLP_S3# from PCH
- iPsPwrok  in  1  delayed PSU power-good
- ivAssertDlyMs  in  DLY_BITS  assert delay in ms
- iSysEnable  in  1  debug-port SYSPWROK enable
- iFaultClr  in  1  one-cycle fault clear
- oPwrok  out  1  aggregated PWROK (PCH_PWROK equivalent)
- oSysPwrok  out  1  oPwrok & iSysEnable, registered
- oFault  out  1  sticky fault flag
- ovFaultRail  out  NUM_RAILS+1  first-fail snapshot; bit NUM_RAILS = PSU, bits [NUM_RAILS-1:0] = rails
- ovState  out  2  current FSM state for debug

Behaviour:
- Reset: all outputs 0, state IDLE, filtered rails 0, counter 0. Reset mid-operation forces these on the next edge.
- Filter, per rail: a per-rail counter tracks cycles where raw != filtered. Filtered takes the raw value when the count reaches DEB_CYCLES-1. Any cycle with raw == filtered clears the count. Result: a level held DEB_CYCLES cycles appears on filtered DEB_CYCLES cycles after the change.
- allGood = &(filtered | ~ivRailMask) & iSlpS3_n & iPsPwrok. A mask of all zeros means only SLP_S3#/PS gate.
- State encodings: IDLE=00, DELAY=01, PWROK=10, FAULT=11.
- IDLE:
  - allGood -> DELAY.
  - On entry to DELAY, ivAssertDlyMs is latched and the counter cleared.
- DELAY:
  - !allGood -> IDLE, no fault.
  - The counter increments on i1mSCE and saturates at all-ones.
  - When counter == latched delay -> PWROK. Delay 0 reaches PWROK on the cycle after DELAY entry.
- PWROK:
  - !iSlpS3_n -> IDLE. This is a normal shutdown, no fault, and it wins over any simultaneous rail or PS drop.
  - Otherwise, any required filtered rail low or !iPsPwrok -> FAULT.
  - On that edge: ovFaultRail <= {~iPsPwrok, ivRailMask & ~filtered}; oFault <= 1. All simultaneous failures are recorded.
- FAULT:
  - iFaultClr -> IDLE; oFault and ovFaultRail cleared on the same edge.
- Sticky fault state:
  - oFault/ovFaultRail change only on entry to FAULT or on iFaultClr.
  - iFaultClr in any state clears them.
  - iFaultClr on the same cycle as FAULT entry: entry wins.
- Outputs:
  - oPwrok = (state == PWROK), decoded from the state register.
  - oSysPwrok <= oPwrok & iSysEnable, one extra cycle of latency.
  - ovState = state register.
- Latency from the first raw rail edge completing allGood to DELAY entry: DEB_CYCLES+1 cycles.

Optional Feature:
- PWRGD_PS_RECOVERY_EN defined:
  - A FAULT whose snapshot has only bit NUM_RAILS set (PSU-only loss) auto-exits to DELAY once allGood holds. The delay is re-latched on that transition.
  - oFault and ovFaultRail stay set until iFaultClr.
  - Any rail-bit fault still requires iFaultClr.
- Undefined: every FAULT requires iFaultClr; no auto-recovery.

Decomposition:
- Shared package pwrgd_pkg holds:
  - state encoding constants ST_IDLE/ST_DELAY/ST_PWROK/ST_FAULT
  - the 2-bit state width
  - DEB_CYCLES default constant
- Sub-module pwrgd_glitch_filter: one instance per rail via generate; parameter DEB_CYCLES; ports iClk, iRst, iIn, oOut.

Test Plan:
- NUM_RAILS=8, mask=8'hFF, dly=6, SLP/PS high, all rails rise at cycle 0 -> DELAY at cycle 4. oPwrok high on the cycle after the 6th i1mSCE. oSysPwrok one cycle later with iSysEnable=1; stays 0 with iSysEnable=0.
- In PWROK, rail 3 low for 2 cycles -> no change. Low for 3 cycles -> FAULT, oPwrok low, ovFaultRail=9'h008, oFault=1. iFaultClr -> IDLE, snapshot 0.
- In PWROK, iSlpS3_n and rail 5 drop on the same cycle -> IDLE, oFault=0, ovFaultRail=0.
- In PWROK, iPsPwrok drops -> ovFaultRail=9'h100. PS returns: with PWRGD_PS_RECOVERY_EN, DELAY, then PWROK with oFault still 1. Without it, remains FAULT.
- mask=8'hFE, rail 0 held low, dly=0 -> PWROK one cycle after DELAY entry. Rail 0 toggling never faults.
- iRst asserted in DELAY and in FAULT -> next edge all outputs 0, ovState=00, filtered rails cleared.
